// File: rtl/bus_pkg.sv
// Shared constants and types for the bus fabric: default widths, master tags,
// and the slave address map.
package bus_pkg;

    localparam int unsigned BUS_AW       = 8;
    localparam int unsigned BUS_DW       = 32;
    localparam int unsigned BUS_SLV_LOG2 = 5;

    localparam logic [7:0] BUS_S0_BASE = 8'h00;
    localparam logic [7:0] BUS_S1_BASE = 8'h20;

    typedef logic [1:0] tag_t;

    localparam tag_t M0 = 2'd0;
    localparam tag_t M1 = 2'd1;
    localparam tag_t M2 = 2'd2;

endpackage

// File: rtl/bus_addr_decoder.sv
// Address decoder for the two slave windows. Purely combinational.
//   addr     : winning master's address
//   active   : a valid transaction is on the bus this cycle
//   s0_sel   : address falls in slave 0's window (wins on overlap)
//   s1_sel   : address falls in slave 1's window
//   unmapped : active transaction that hits neither window
module bus_addr_decoder
    import bus_pkg::*;
#(
    parameter int unsigned     AW       = BUS_AW,
    parameter int unsigned     SLV_LOG2 = BUS_SLV_LOG2,
    parameter logic [AW-1:0]   S0_BASE  = AW'(BUS_S0_BASE),
    parameter logic [AW-1:0]   S1_BASE  = AW'(BUS_S1_BASE)
) (
    input  logic [AW-1:0] addr,
    input  logic          active,
    output logic          s0_sel,
    output logic          s1_sel,
    output logic          unmapped
);

    // Masking keeps only the window-select bits; the in-window offset is ignored.
    localparam logic [AW-1:0] HI_MASK = ~((AW'(1) << SLV_LOG2) - AW'(1));

    logic hit0;
    logic hit1;

    assign hit0 = (addr & HI_MASK) == (S0_BASE & HI_MASK);
    assign hit1 = (addr & HI_MASK) == (S1_BASE & HI_MASK);

    assign s0_sel   = active & hit0;
    assign s1_sel   = active & hit1 & ~hit0;
    assign unmapped = active & ~hit0 & ~hit1;

endmodule

// File: rtl/bus_fabric.sv
// Bus fabric: routes the granted master's command to one of two slaves and
// returns registered read data, tagged back to the issuing master.
// Optional feature macro: BUS_FABRIC_ERR_EN (adds registered m_err output
// flagging unmapped accesses).
//   clk, reset_n                 : clock, synchronous active-low reset
//   mN_grant/valid/we/addr/wdata : per-master grant and command
//   s0_sel, s1_sel               : slave chip selects
//   s_we, s_addr, s_wdata        : muxed command to slaves
//   s0_rdata, s1_rdata           : slave read data (combinational on s_addr)
//   m_rdata                      : registered read data, shared by masters
//   mN_rvalid                    : read-return strobe for master N
//   m_err                        : unmapped-access flag (BUS_FABRIC_ERR_EN)
module bus_fabric
    import bus_pkg::*;
#(
    parameter int unsigned     AW       = BUS_AW,
    parameter int unsigned     DW       = BUS_DW,
    parameter logic [AW-1:0]   S0_BASE  = AW'(BUS_S0_BASE),
    parameter logic [AW-1:0]   S1_BASE  = AW'(BUS_S1_BASE),
    parameter int unsigned     SLV_LOG2 = BUS_SLV_LOG2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_grant,
    input  logic          m0_valid,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_grant,
    input  logic          m1_valid,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m2_grant,
    input  logic          m2_valid,
    input  logic          m2_we,
    input  logic [AW-1:0] m2_addr,
    input  logic [DW-1:0] m2_wdata,
    output logic          s0_sel,
    output logic          s1_sel,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s0_rdata,
    input  logic [DW-1:0] s1_rdata,
    output logic [DW-1:0] m_rdata,
`ifdef BUS_FABRIC_ERR_EN
    output logic          m_err,
`endif
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic          m2_rvalid
);

    logic          win_found;
    tag_t          win_tag;
    logic          win_valid;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    logic          active;
    logic          unmapped;
    logic          read_fire;
    logic          ret_fire;
    logic [DW-1:0] rdata_sel;

    logic          rvalid_q;
    tag_t          tag_q;

    // Winner select: first asserted grant in priority order m0, m1, m2.
    always_comb begin
        win_found = 1'b0;
        win_tag   = M0;
        win_valid = 1'b0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        if (m0_grant) begin
            win_found = 1'b1;
            win_tag   = M0;
            win_valid = m0_valid;
            win_we    = m0_we;
            win_addr  = m0_addr;
            win_wdata = m0_wdata;
        end else if (m1_grant) begin
            win_found = 1'b1;
            win_tag   = M1;
            win_valid = m1_valid;
            win_we    = m1_we;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end else if (m2_grant) begin
            win_found = 1'b1;
            win_tag   = M2;
            win_valid = m2_valid;
            win_we    = m2_we;
            win_addr  = m2_addr;
            win_wdata = m2_wdata;
        end
    end

    assign s_we    = win_we;
    assign s_addr  = win_addr;
    assign s_wdata = win_wdata;

    // Folding reset_n in here keeps the selects low during reset.
    assign active = win_found & win_valid & reset_n;

    bus_addr_decoder #(
        .AW       (AW),
        .SLV_LOG2 (SLV_LOG2),
        .S0_BASE  (S0_BASE),
        .S1_BASE  (S1_BASE)
    ) u_decoder (
        .addr     (win_addr),
        .active   (active),
        .s0_sel   (s0_sel),
        .s1_sel   (s1_sel),
        .unmapped (unmapped)
    );

    assign rdata_sel = s0_sel ? s0_rdata : (s1_sel ? s1_rdata : '0);
    assign read_fire = active & ~win_we;

`ifdef BUS_FABRIC_ERR_EN
    // Unmapped writes also get a return strobe so the master sees the error.
    assign ret_fire = active & (~win_we | unmapped);
`else
    assign ret_fire = read_fire;
`endif

    // Return register: data, strobe and issuing-master tag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_rdata  <= '0;
            rvalid_q <= 1'b0;
            tag_q    <= M0;
        end else begin
            rvalid_q <= ret_fire;
            if (ret_fire) begin
                tag_q <= win_tag;
            end
            if (read_fire) begin
                m_rdata <= rdata_sel;
            end
        end
    end

`ifdef BUS_FABRIC_ERR_EN
    // Error flag pulses alongside the return strobe of an unmapped access.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m_err <= 1'b0;
        end else begin
            m_err <= unmapped;
        end
    end
`endif

    // Strobes decode from registered state only, so the tag set at issue time
    // decides the recipient regardless of the current grant.
    assign m0_rvalid = rvalid_q & (tag_q == M0);
    assign m1_rvalid = rvalid_q & (tag_q == M1);
    assign m2_rvalid = rvalid_q & (tag_q == M2);

endmodule
